// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : Circular reorder buffer. Allocates one entry per dispatched
//               instruction, records completions from the CDB and retires
//               entries in program order, one per cycle. A mispredicted branch
//               raises a flush when it reaches the head of the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int PC_W   = 9,
    parameter int AREG_W = 5,
    parameter int PREG_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_alloc_valid,
    input  logic [PC_W-1:0]   i_alloc_pc,
    input  logic              i_alloc_has_rd,
    input  logic [AREG_W-1:0] i_alloc_rd_arch,
    input  logic [PREG_W-1:0] i_alloc_rd_phys,
    input  logic [PREG_W-1:0] i_alloc_old_phys,
    output logic              o_alloc_ready,
    output logic [TAG_W-1:0]  o_alloc_tag,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic              i_cdb_mispredict,
    input  logic [PC_W-1:0]   i_cdb_target,
    output logic              o_commit_valid,
    output logic [PC_W-1:0]   o_commit_pc,
    output logic              o_commit_has_rd,
    output logic [AREG_W-1:0] o_commit_rd_arch,
    output logic [PREG_W-1:0] o_commit_rd_phys,
    output logic [PREG_W-1:0] o_commit_old_phys,
    output logic              o_flush,
    output logic [PC_W-1:0]   o_flush_pc,
    output logic [TAG_W-1:0]  o_head_ptr,
    output logic [TAG_W-1:0]  o_tail_ptr,
    output logic [TAG_W:0]    o_count
);

    localparam logic [TAG_W:0]   c_FULL    = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   c_CNT_ONE = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] c_PTR_ONE = TAG_W'(1);

    // Per-entry status bits (cleared by reset, commit and flush)
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  r_mispred;

    // Per-entry payload (only meaningful while the matching valid bit is set)
    logic [DEPTH-1:0]  r_has_rd;
    logic [PC_W-1:0]   r_pc       [DEPTH];
    logic [PC_W-1:0]   r_target   [DEPTH];
    logic [AREG_W-1:0] r_rd_arch  [DEPTH];
    logic [PREG_W-1:0] r_rd_phys  [DEPTH];
    logic [PREG_W-1:0] r_old_phys [DEPTH];

    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic w_commit;
    logic w_flush;
    logic w_alloc_fire;
    logic w_cdb_hit;

    // Commit, flush and allocation handshakes decoded from registered state
    always_comb begin
        w_commit     = r_valid[r_head] && r_done[r_head];
        w_flush      = w_commit && r_mispred[r_head];
        // Full blocks allocation even if the head retires this cycle
        o_alloc_ready = (r_count != c_FULL) && !w_flush;
        w_alloc_fire = i_alloc_valid && o_alloc_ready;
        w_cdb_hit    = i_cdb_valid && r_valid[i_cdb_tag];

        o_alloc_tag       = r_tail;
        o_head_ptr        = r_head;
        o_tail_ptr        = r_tail;
        o_count           = r_count;
        o_commit_valid    = w_commit;
        o_flush           = w_flush;
        o_flush_pc        = w_flush  ? r_target[r_head]   : '0;
        o_commit_pc       = w_commit ? r_pc[r_head]       : '0;
        o_commit_has_rd   = w_commit ? r_has_rd[r_head]   : 1'b0;
        o_commit_rd_arch  = w_commit ? r_rd_arch[r_head]  : '0;
        o_commit_rd_phys  = w_commit ? r_rd_phys[r_head]  : '0;
        o_commit_old_phys = w_commit ? r_old_phys[r_head] : '0;
    end

    // Entry status, pointers and occupancy; a flush wipes everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid   <= '0;
            r_done    <= '0;
            r_mispred <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
        end else if (w_flush) begin
            r_valid   <= '0;
            r_done    <= '0;
            r_mispred <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
        end else begin
            if (w_cdb_hit) begin
                r_done[i_cdb_tag]    <= 1'b1;
                r_mispred[i_cdb_tag] <= i_cdb_mispredict;
            end
            // Later assignments win: a retiring head is cleared even if the
            // CDB re-reports it in the same cycle
            if (w_commit) begin
                r_valid[r_head]   <= 1'b0;
                r_done[r_head]    <= 1'b0;
                r_mispred[r_head] <= 1'b0;
                r_head            <= r_head + c_PTR_ONE;
            end
            if (w_alloc_fire) begin
                r_valid[r_tail]   <= 1'b1;
                r_done[r_tail]    <= 1'b0;
                r_mispred[r_tail] <= 1'b0;
                r_tail            <= r_tail + c_PTR_ONE;
            end
            case ({w_alloc_fire, w_commit})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload capture at allocation and branch target capture at completion
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_pc[r_tail]       <= i_alloc_pc;
            r_has_rd[r_tail]   <= i_alloc_has_rd;
            r_rd_arch[r_tail]  <= i_alloc_rd_arch;
            r_rd_phys[r_tail]  <= i_alloc_rd_phys;
            r_old_phys[r_tail] <= i_alloc_old_phys;
        end
        if (w_cdb_hit && !w_flush) begin
            r_target[i_cdb_tag] <= i_cdb_target;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Self-checking bench for reorder_buffer. A program-order queue
//               of in-flight instructions acts as reference model and
//               scoreboard; a negedge monitor pops retirements and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       alloc_valid = 1'b0;
    logic [8:0] alloc_pc = '0;
    logic       alloc_has_rd = 1'b0;
    logic [4:0] alloc_rd_arch = '0;
    logic [6:0] alloc_rd_phys = '0;
    logic [6:0] alloc_old_phys = '0;
    logic       alloc_ready;
    logic [3:0] alloc_tag;
    logic       cdb_valid = 1'b0;
    logic [3:0] cdb_tag = '0;
    logic       cdb_mispredict = 1'b0;
    logic [8:0] cdb_target = '0;
    logic       commit_valid;
    logic [8:0] commit_pc;
    logic       commit_has_rd;
    logic [4:0] commit_rd_arch;
    logic [6:0] commit_rd_phys;
    logic [6:0] commit_old_phys;
    logic       flush;
    logic [8:0] flush_pc;
    logic [3:0] head_ptr;
    logic [3:0] tail_ptr;
    logic [4:0] count;

    reorder_buffer dut (
        .clk               (clk),
        .rst               (rst),
        .i_alloc_valid     (alloc_valid),
        .i_alloc_pc        (alloc_pc),
        .i_alloc_has_rd    (alloc_has_rd),
        .i_alloc_rd_arch   (alloc_rd_arch),
        .i_alloc_rd_phys   (alloc_rd_phys),
        .i_alloc_old_phys  (alloc_old_phys),
        .o_alloc_ready     (alloc_ready),
        .o_alloc_tag       (alloc_tag),
        .i_cdb_valid       (cdb_valid),
        .i_cdb_tag         (cdb_tag),
        .i_cdb_mispredict  (cdb_mispredict),
        .i_cdb_target      (cdb_target),
        .o_commit_valid    (commit_valid),
        .o_commit_pc       (commit_pc),
        .o_commit_has_rd   (commit_has_rd),
        .o_commit_rd_arch  (commit_rd_arch),
        .o_commit_rd_phys  (commit_rd_phys),
        .o_commit_old_phys (commit_old_phys),
        .o_flush           (flush),
        .o_flush_pc        (flush_pc),
        .o_head_ptr        (head_ptr),
        .o_tail_ptr        (tail_ptr),
        .o_count           (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int pc;
        int has_rd;
        int rd_arch;
        int rd_phys;
        int old_phys;
        bit done;
        bit misp;
        int target;
    } ent_t;

    // In-flight instructions, oldest first
    ent_t mq[$];
    int   m_head = 0;
    int   m_tail = 0;
    bit   m_ready = 1'b1;
    bit   m_commit = 1'b0;
    bit   m_flush = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference model state update at each edge, using the decisions the
    // monitor made on the preceding negedge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_head   = 0;
            m_tail   = 0;
            m_ready  = 1'b1;
            m_commit = 1'b0;
            m_flush  = 1'b0;
        end else begin
            if (m_flush) begin
                mq.delete();
                m_head = 0;
                m_tail = 0;
            end else begin
                if (m_commit) m_head = (m_head + 1) % DEPTH;
                if (cdb_valid) begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (mq[i].tag == int'(cdb_tag)) begin
                            ent_t t;
                            t = mq[i];
                            t.done   = 1'b1;
                            t.misp   = cdb_mispredict;
                            t.target = int'(cdb_target);
                            mq[i] = t;
                        end
                    end
                end
                if (alloc_valid && m_ready) begin
                    ent_t n;
                    n.tag      = m_tail;
                    n.pc       = int'(alloc_pc);
                    n.has_rd   = int'(alloc_has_rd);
                    n.rd_arch  = int'(alloc_rd_arch);
                    n.rd_phys  = int'(alloc_rd_phys);
                    n.old_phys = int'(alloc_old_phys);
                    n.done     = 1'b0;
                    n.misp     = 1'b0;
                    n.target   = 0;
                    mq.push_back(n);
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
            m_commit = 1'b0;
            m_flush  = 1'b0;
        end
    end

    // Monitor: compare DUT outputs against the model; pop retiring entries
    always @(negedge clk) begin
        bit   exp_commit;
        bit   exp_flush;
        ent_t e;
        exp_commit = (mq.size() > 0) && mq[0].done;
        exp_flush  = exp_commit && mq[0].misp;
        chk("commit_valid", int'(commit_valid), int'(exp_commit));
        chk("flush", int'(flush), int'(exp_flush));
        chk("alloc_ready", int'(alloc_ready), int'((mq.size() < DEPTH) && !exp_flush));
        chk("alloc_tag", int'(alloc_tag), m_tail);
        chk("tail_ptr", int'(tail_ptr), m_tail);
        chk("head_ptr", int'(head_ptr), m_head);
        chk("count", int'(count), mq.size());
        if (exp_commit) begin
            e = mq.pop_front();
            chk("commit_tag_vs_head", m_head, e.tag);
            chk("commit_pc", int'(commit_pc), e.pc);
            chk("commit_has_rd", int'(commit_has_rd), e.has_rd);
            chk("commit_rd_arch", int'(commit_rd_arch), e.rd_arch);
            chk("commit_rd_phys", int'(commit_rd_phys), e.rd_phys);
            chk("commit_old_phys", int'(commit_old_phys), e.old_phys);
            chk("flush_pc", int'(flush_pc), exp_flush ? e.target : 0);
        end else begin
            chk("commit_fields_idle", int'({commit_pc, commit_has_rd, commit_rd_arch, commit_rd_phys, commit_old_phys}), 0);
            chk("flush_pc_idle", int'(flush_pc), 0);
        end
        m_ready  = ((mq.size() + (exp_commit ? 1 : 0)) < DEPTH) && !exp_flush;
        m_commit = exp_commit;
        m_flush  = exp_flush;
    end

    // Drive one cycle of inputs, held across the next rising edge
    task automatic cyc(input bit av, input int pc, input bit cv, input int tag,
                       input bit mis, input int tgt);
        alloc_valid    = av;
        alloc_pc       = 9'(pc);
        alloc_has_rd   = 1'($urandom);
        alloc_rd_arch  = 5'($urandom);
        alloc_rd_phys  = 7'($urandom);
        alloc_old_phys = 7'($urandom);
        cdb_valid      = cv;
        cdb_tag        = 4'(tag);
        cdb_mispredict = mis;
        cdb_target     = 9'(tgt);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic do_reset(input int n);
        #2;
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        // Reset held for five cycles
        do_reset(5);
        chk("rst_count", int'(count), 0);
        chk("rst_alloc_tag", int'(alloc_tag), 0);
        chk("rst_alloc_ready", int'(alloc_ready), 1);
        chk("rst_commit_valid", int'(commit_valid), 0);
        chk("rst_flush", int'(flush), 0);

        // Four allocations, out-of-order completion, in-order retirement
        for (int i = 0; i < 4; i++) cyc(1'b1, i * 4, 1'b0, 0, 1'b0, 0);
        chk("alloc4_count", int'(count), 4);
        chk("alloc4_tail", int'(tail_ptr), 4);
        cyc(1'b0, 0, 1'b1, 2, 1'b0, 0);
        cyc(1'b0, 0, 1'b1, 0, 1'b0, 0);
        cyc(1'b0, 0, 1'b0, 0, 1'b0, 0);
        cyc(1'b0, 0, 1'b1, 1, 1'b0, 0);
        idle(2);
        cyc(1'b0, 0, 1'b1, 3, 1'b0, 0);
        idle(2);

        // Fill to capacity, overflow request ignored, wrap after one retire
        do_reset(2);
        for (int i = 0; i < 17; i++) cyc(1'b1, 9'h100 + i, 1'b0, 0, 1'b0, 0);
        chk("full_count", int'(count), 16);
        chk("full_ready", int'(alloc_ready), 0);
        cyc(1'b0, 0, 1'b1, 0, 1'b0, 0);
        idle(1);
        chk("wrap_count", int'(count), 15);
        chk("wrap_tag", int'(alloc_tag), 0);
        cyc(1'b1, 9'h1AB, 1'b0, 0, 1'b0, 0);
        idle(2);

        // Mispredicted branch behind a normal instruction, younger work done
        do_reset(2);
        for (int i = 0; i < 4; i++) cyc(1'b1, 9'h20 + i * 4, 1'b0, 0, 1'b0, 0);
        cyc(1'b0, 0, 1'b1, 2, 1'b0, 0);
        cyc(1'b0, 0, 1'b1, 3, 1'b0, 0);
        cyc(1'b0, 0, 1'b1, 1, 1'b1, 9'h40);
        cyc(1'b0, 0, 1'b1, 0, 1'b0, 0);
        idle(1);
        chk("flush_seen", int'(flush), 1);
        chk("flush_pc_val", int'(flush_pc), 9'h40);
        idle(1);
        chk("post_flush_count", int'(count), 0);
        chk("post_flush_head", int'(head_ptr), 0);
        idle(3);

        // Asynchronous reset in the middle of a cycle with 7 entries live
        for (int i = 0; i < 7; i++) cyc(1'b1, 9'h60 + i, 1'b0, 0, 1'b0, 0);
        cyc(1'b0, 0, 1'b1, 0, 1'b0, 0);
        chk("pre_async_count", int'(count), 7);
        #2;
        rst = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_commit_valid", int'(commit_valid), 0);
        chk("async_head", int'(head_ptr), 0);
        chk("async_tail", int'(tail_ptr), 0);
        chk("async_ready", int'(alloc_ready), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("async_first_tag", int'(alloc_tag), 0);
        cyc(1'b1, 9'h77, 1'b0, 0, 1'b0, 0);
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit av;
            bit cv;
            bit mis;
            int tag;
            av  = ($urandom_range(99) < 60);
            cv  = ($urandom_range(99) < 55);
            mis = ($urandom_range(99) < 4);
            if (mq.size() > 0 && $urandom_range(99) < 80)
                tag = mq[$urandom_range(mq.size() - 1)].tag;
            else
                tag = $urandom_range(DEPTH - 1);
            cyc(av, $urandom_range(511), cv, tag, mis, $urandom_range(511));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
